// File: rtl/aes_cipher_core_pkg.sv
// rtl/aes_cipher_core_pkg.sv - shared AES constants, FSM encoding and GF(2^8) helpers
package aes_cipher_core_pkg;
  localparam int AES_BLOCK = 128;
  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_fsm_e;

  // Entry 0x00 is the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic nr_is_legal(input int nr);
    return (nr == NR_AES128) || (nr == NR_AES192) || (nr == NR_AES256);
  endfunction
endpackage

// File: rtl/aes_round.sv
// rtl/aes_round.sv - one combinational AES round; MixColumns is bypassed on the last round
module aes_round
  import aes_cipher_core_pkg::*;
(
  input  logic [AES_BLOCK-1:0] state,
  input  logic [AES_BLOCK-1:0] key,
  input  logic                 last_round,
  output logic [AES_BLOCK-1:0] next_state
);
  logic [AES_BLOCK-1:0] sb;
  logic [AES_BLOCK-1:0] sr;
  logic [AES_BLOCK-1:0] mc;

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[AES_BLOCK-1-8*i -: 8] = sbox(state[AES_BLOCK-1-8*i -: 8]);
  end

  // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int I  = 4*c + r;
      localparam int J  = 4*((c+r)%4) + r;
      localparam int R1 = 4*c + (r+1)%4;
      localparam int R2 = 4*c + (r+2)%4;
      localparam int R3 = 4*c + (r+3)%4;
      assign sr[AES_BLOCK-1-8*I -: 8] = sb[AES_BLOCK-1-8*J -: 8];
      assign mc[AES_BLOCK-1-8*I -: 8] = xtime(sr[AES_BLOCK-1-8*I -: 8])
                                      ^ xtime(sr[AES_BLOCK-1-8*R1 -: 8])
                                      ^ sr[AES_BLOCK-1-8*R1 -: 8]
                                      ^ sr[AES_BLOCK-1-8*R2 -: 8]
                                      ^ sr[AES_BLOCK-1-8*R3 -: 8];
    end
  end

  assign next_state = (last_round ? sr : mc) ^ key;
endmodule

// File: rtl/aes_cipher_core.sv
// rtl/aes_cipher_core.sv - iterative AES encryption core, one round per clock
module aes_cipher_core
  import aes_cipher_core_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [AES_BLOCK-1:0]         in_block,
  input  logic [AES_BLOCK*(NR+1)-1:0]  round_keys,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [AES_BLOCK-1:0]         out_block,
  output logic                         busy
);
  localparam int RW = $clog2(NR+1);
  localparam int KW = AES_BLOCK*(NR+1);

  if (!nr_is_legal(NR)) begin : g_bad_nr
    $error("aes_cipher_core: NR must be 10, 12 or 14");
  end

  aes_fsm_e             fsm_q, fsm_d;
  logic [RW-1:0]        rnd_q, rnd_d;
  logic [AES_BLOCK-1:0] state_q, state_d;
  logic [KW-1:0]        keys_q;
  logic [AES_BLOCK-1:0] rk [NR+1];
  logic [AES_BLOCK-1:0] round_out;
  logic                 accept;
  logic                 last_round;

  for (genvar r = 0; r <= NR; r++) begin : g_rk
    assign rk[r] = keys_q[KW-1-AES_BLOCK*r -: AES_BLOCK];
  end

  assign accept     = (fsm_q == ST_IDLE) && in_valid;
  assign last_round = (rnd_q == RW'(NR));

  aes_round u_round (
    .state      (state_q),
    .key        (rk[rnd_q]),
    .last_round (last_round),
    .next_state (round_out)
  );

  // Round key 0 is applied straight from the input on the accept edge.
  always_comb begin
    fsm_d   = fsm_q;
    rnd_d   = rnd_q;
    state_d = state_q;
    case (fsm_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = in_block ^ round_keys[KW-1 -: AES_BLOCK];
          rnd_d   = RW'(1);
          fsm_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        state_d = round_out;
        if (last_round) begin
          fsm_d = ST_DONE;
        end else begin
          rnd_d = rnd_q + RW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          fsm_d = ST_IDLE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= ST_IDLE;
      rnd_q   <= '0;
      state_q <= '0;
      keys_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
      if (accept) begin
        keys_q <= round_keys;
      end
    end
  end

  assign in_ready  = (fsm_q == ST_IDLE);
  assign out_valid = (fsm_q == ST_DONE);
  assign busy      = (fsm_q == ST_ROUND);
  assign out_block = state_q;
endmodule

// File: tb/tb_aes_cipher_core.sv
// tb/tb_aes_cipher_core.sv - randomized self-checking bench with a behavioural AES model
module tb_aes_cipher_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [2:0]    in_valid_v;
  logic [2:0]    in_ready_v;
  logic [2:0]    out_valid_v;
  logic [2:0]    busy_v;
  logic          out_ready;
  logic [127:0]  in_block;
  logic [1919:0] rk_all;
  logic [127:0]  out_blk [3];

  int checks = 0;
  int failures = 0;

  aes_cipher_core #(.NR(10)) u_dut10 (
    .clk(clk), .reset(reset), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_block(in_block), .round_keys(rk_all[1919 -: 1408]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .out_block(out_blk[0]), .busy(busy_v[0]));
  aes_cipher_core #(.NR(12)) u_dut12 (
    .clk(clk), .reset(reset), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_block(in_block), .round_keys(rk_all[1919 -: 1664]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .out_block(out_blk[1]), .busy(busy_v[1]));
  aes_cipher_core #(.NR(14)) u_dut14 (
    .clk(clk), .reset(reset), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_block(in_block), .round_keys(rk_all[1919 -: 1920]), .out_valid(out_valid_v[2]),
    .out_ready(out_ready), .out_block(out_blk[2]), .busy(busy_v[2]));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", nm, act, req);
    end
  endtask

  // ---------------- behavioural AES model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] v, input int k);
    logic [15:0] d = {v, v};
    return d[15-k -: 8];
  endfunction

  // S-box from the field inverse (x^254) followed by the affine map.
  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] p = x;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      inv = gmul(inv, p);
    end
    return inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])};
  endfunction

  function automatic logic [1919:0] m_expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [1919:0] res = '0;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          t = subword(t);
        end
        w[i] = w[i-nk] ^ t;
      end
      res[1919-32*i -: 32] = w[i];
    end
    return res;
  endfunction

  function automatic logic [127:0] m_encrypt(input logic [127:0] pt, input logic [1919:0] rk, input int nr);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] k;
    logic [127:0] o;
    k = rk[1919 -: 128];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(4*c+r) -: 8] ^ k[127-8*(4*c+r) -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      k = rk[1919-128*rd -: 128];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = m_sbox(s[r][(c+r)%4]);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] = (rd < nr) ? (gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                                 ^ t[(r+2)%4][c] ^ t[(r+3)%4][c]) : t[r][c];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] ^= k[127-8*(4*c+r) -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[r][c];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [1919:0] rand1920();
    logic [1919:0] v;
    for (int i = 0; i < 60; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- cycle-level model of the NR=10 instance ----------------
  typedef enum int {M_IDLE, M_RUN, M_DONE} mph_e;
  mph_e         m_ph = M_IDLE;
  int           m_left = 0;
  bit           m_zero = 1'b1;
  int           cyc = 0;
  logic [127:0] m_exp = '0;
  int           acc_cyc [$];
  logic [127:0] exp_q [$];

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_ph = M_IDLE;
      m_zero = 1'b1;
      exp_q.delete();
    end else begin
      cyc++;
      case (m_ph)
        M_IDLE: if (in_valid_v[0]) begin
          m_exp = m_encrypt(in_block, {rk_all[1919 -: 1408], 512'b0}, 10);
          m_left = 10;
          m_ph = M_RUN;
          m_zero = 1'b0;
          acc_cyc.push_back(cyc);
          exp_q.push_back(m_exp);
        end
        M_RUN: begin
          m_left--;
          if (m_left == 0) m_ph = M_DONE;
        end
        M_DONE: if (out_ready) m_ph = M_IDLE;
        default: m_ph = M_IDLE;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    chk1("in_ready", in_ready_v[0], m_ph == M_IDLE);
    chk1("out_valid", out_valid_v[0], m_ph == M_DONE);
    chk1("busy", busy_v[0], m_ph == M_RUN);
    if (m_zero) chk("out_block_zero", out_blk[0], 128'h0);
    if (m_ph == M_DONE) begin
      chk("out_block", out_blk[0], m_exp);
      if (out_ready) begin
        chk1("order_pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk("order", out_blk[0], exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Caller is positioned just after a rising edge with the target instance idle.
  task automatic kat(input int idx, input int nr, input logic [127:0] pt, input logic [1919:0] rk,
                     input logic [127:0] req, input bit scramble, input string nm);
    int n;
    in_block = pt;
    rk_all = rk;
    in_valid_v[idx] = 1'b1;
    step();
    in_valid_v[idx] = 1'b0;
    chk1({nm, "_accept"}, busy_v[idx], 1'b1);
    if (scramble) begin
      rk_all = rand1920();
      in_block = rand128();
    end
    n = 1;
    while (!out_valid_v[idx] && n < 40) begin
      step();
      n++;
    end
    chk({nm, "_latency"}, 128'(n), 128'(nr + 1));
    chk({nm, "_ct"}, out_blk[idx], req);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk1({nm, "_idle"}, in_ready_v[idx], 1'b1);
  endtask

  localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] KEY1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY2 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin
    logic [127:0]  pt;
    logic [1919:0] rk;
    reset = 1'b1;
    in_valid_v = 3'b000;
    out_ready = 1'b0;
    in_block = '0;
    rk_all = '0;
    repeat (3) step();

    chk1("rst_in_ready", in_ready_v[0], 1'b1);
    chk1("rst_out_valid", out_valid_v[0], 1'b0);
    chk1("rst_busy", busy_v[0], 1'b0);
    chk("rst_out_block", out_blk[0], 128'h0);
    chk1("rst_in_ready12", in_ready_v[1], 1'b1);
    chk1("rst_in_ready14", in_ready_v[2], 1'b1);

    chk("model_fips", m_encrypt(PT1, m_expand(KEY1, 4, 10), 10), CT1);
    chk("model_nr10", m_encrypt(PT2, m_expand(KEY2, 4, 10), 10), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("model_nr12", m_encrypt(PT2, m_expand(KEY2, 6, 12), 12), 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    chk("model_nr14", m_encrypt(PT2, m_expand(KEY2, 8, 14), 14), 128'h8ea2b7ca516745bfeafc49904b496089);

    // First accept lands on the first edge after reset release.
    reset = 1'b0;
    kat(0, 10, PT1, m_expand(KEY1, 4, 10), CT1, 1'b0, "kat_fips");
    kat(0, 10, PT2, m_expand(KEY2, 4, 10), 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, "kat_nr10");
    kat(1, 12, PT2, m_expand(KEY2, 6, 12), 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 1'b0, "kat_nr12");
    kat(2, 14, PT2, m_expand(KEY2, 8, 14), 128'h8ea2b7ca516745bfeafc49904b496089, 1'b0, "kat_nr14");
    kat(0, 10, PT1, m_expand(KEY1, 4, 10), CT1, 1'b1, "key_latch");

    // Backpressure with stray in_valid pulses.
    in_block = rand128();
    rk_all = rand1920();
    in_valid_v[0] = 1'b1;
    step();
    in_valid_v[0] = 1'b0;
    for (int i = 0; i < 40 && !out_valid_v[0]; i++) step();
    chk1("bp_done", out_valid_v[0], 1'b1);
    for (int i = 0; i < 20; i++) begin
      in_valid_v[0] = 1'($urandom_range(0, 1));
      in_block = rand128();
      rk_all = rand1920();
      step();
      chk1("bp_hold_valid", out_valid_v[0], 1'b1);
      chk1("bp_no_ready", in_ready_v[0], 1'b0);
    end
    in_valid_v[0] = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Back-to-back with fresh random data every cycle.
    acc_cyc.delete();
    in_valid_v[0] = 1'b1;
    out_ready = 1'b1;
    repeat (72) begin
      in_block = rand128();
      rk_all = rand1920();
      step();
    end
    in_valid_v[0] = 1'b0;
    repeat (15) step();
    out_ready = 1'b0;
    chk1("b2b_count", acc_cyc.size() >= 5, 1'b1);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("b2b_spacing", 128'(acc_cyc[i] - acc_cyc[i-1]), 128'd12);

    // Reset during round 5 discards the block.
    in_block = rand128();
    rk_all = rand1920();
    in_valid_v[0] = 1'b1;
    step();
    in_valid_v[0] = 1'b0;
    repeat (4) step();
    chk1("pre_rst_busy", busy_v[0], 1'b1);
    reset = 1'b1;
    #1;
    chk1("mid_rst_in_ready", in_ready_v[0], 1'b1);
    chk1("mid_rst_busy", busy_v[0], 1'b0);
    chk("mid_rst_out_block", out_blk[0], 128'h0);
    repeat (2) step();
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk1("rst_no_out", out_valid_v[0], 1'b0);
    end
    for (int j = 0; j < 3; j++) begin
      pt = rand128();
      rk = rand1920();
      kat(0, 10, pt, rk, m_encrypt(pt, rk, 10), 1'b1, "post_reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
